// File: rtl/siso_shift_sched.sv
// Round-robin scheduler that feeds one SISO shift chain from two requesters.
// Words go out LSB-first in bursts of SHIFT_CYC shift cycles separated by HOLD_CYC holds.
module siso_shift_sched #(
    parameter int WIDTH     = 8,
    parameter int SHIFT_CYC = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             shift_en,
    output logic             sdo,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int BW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(SHIFT_CYC + 1);
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH);
    localparam logic [SW-1:0] BURST_LAST = SW'(SHIFT_CYC);
    localparam logic [HW-1:0] HOLD_LAST  = HW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    logic [1:0]       state_r, state_s;
    logic [1:0]       gnt_r, gnt_s;
    logic             busy_r, busy_s;
    logic             shift_en_r, shift_en_s;
    logic             sdo_r, sdo_s;
    logic             done_r, done_s;
    logic             ptr_r, ptr_s;
    logic [WIDTH-1:0] sreg_r, sreg_s;
    logic [BW-1:0]    bit_cnt_r, bit_cnt_s;
    logic [SW-1:0]    burst_cnt_r, burst_cnt_s;
    logic [HW-1:0]    hold_cnt_r, hold_cnt_s;

    logic             win_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] shifted_s;
    logic [BW-1:0]    bit_inc_s;
    logic [SW-1:0]    burst_inc_s;

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_s     = state_r;
        gnt_s       = gnt_r;
        busy_s      = busy_r;
        shift_en_s  = shift_en_r;
        sdo_s       = sdo_r;
        done_s      = 1'b0;
        ptr_s       = ptr_r;
        sreg_s      = sreg_r;
        bit_cnt_s   = bit_cnt_r;
        burst_cnt_s = burst_cnt_r;
        hold_cnt_s  = hold_cnt_r;

        // Both requesting: the pointer decides; otherwise the lone requester wins.
        win_s       = (req == 2'b11) ? ptr_r : req[1];
        word_s      = win_s ? data1 : data0;
        shifted_s   = sreg_r >> 1;
        bit_inc_s   = bit_cnt_r + BW'(1);
        burst_inc_s = burst_cnt_r + SW'(1);

        case (state_r)
            S_IDLE: begin
                if (req != 2'b00) begin
                    state_s     = S_SHIFT;
                    gnt_s       = win_s ? 2'b10 : 2'b01;
                    busy_s      = 1'b1;
                    shift_en_s  = 1'b1;
                    sreg_s      = word_s;
                    sdo_s       = word_s[0];
                    ptr_s       = ~win_s;
                    bit_cnt_s   = '0;
                    burst_cnt_s = '0;
                    hold_cnt_s  = '0;
                end else begin
                    state_s    = S_IDLE;
                    gnt_s      = 2'b00;
                    busy_s     = 1'b0;
                    shift_en_s = 1'b0;
                    sdo_s      = 1'b0;
                end
            end
            S_SHIFT: begin
                sreg_s    = shifted_s;
                bit_cnt_s = bit_inc_s;
                if (bit_inc_s == BIT_LAST) begin
                    state_s    = S_DONE;
                    shift_en_s = 1'b0;
                    sdo_s      = 1'b0;
                    done_s     = 1'b1;
                end else if (burst_inc_s == BURST_LAST) begin
                    burst_cnt_s = '0;
                    sdo_s       = shifted_s[0];
                    if (HOLD_CYC > 0) begin
                        state_s    = S_HOLD;
                        shift_en_s = 1'b0;
                        hold_cnt_s = '0;
                    end else begin
                        state_s    = S_SHIFT;
                        shift_en_s = 1'b1;
                    end
                end else begin
                    burst_cnt_s = burst_inc_s;
                    sdo_s       = shifted_s[0];
                end
            end
            S_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_s    = S_SHIFT;
                    shift_en_s = 1'b1;
                    hold_cnt_s = '0;
                end else begin
                    hold_cnt_s = hold_cnt_r + HW'(1);
                end
            end
            S_DONE: begin
                state_s    = S_IDLE;
                gnt_s      = 2'b00;
                busy_s     = 1'b0;
                shift_en_s = 1'b0;
                sdo_s      = 1'b0;
            end
            default: begin
                state_s    = S_IDLE;
                gnt_s      = 2'b00;
                busy_s     = 1'b0;
                shift_en_s = 1'b0;
                sdo_s      = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            gnt_r       <= 2'b00;
            busy_r      <= 1'b0;
            shift_en_r  <= 1'b0;
            sdo_r       <= 1'b0;
            done_r      <= 1'b0;
            ptr_r       <= 1'b0;
            sreg_r      <= '0;
            bit_cnt_r   <= '0;
            burst_cnt_r <= '0;
            hold_cnt_r  <= '0;
        end else begin
            state_r     <= state_s;
            gnt_r       <= gnt_s;
            busy_r      <= busy_s;
            shift_en_r  <= shift_en_s;
            sdo_r       <= sdo_s;
            done_r      <= done_s;
            ptr_r       <= ptr_s;
            sreg_r      <= sreg_s;
            bit_cnt_r   <= bit_cnt_s;
            burst_cnt_r <= burst_cnt_s;
            hold_cnt_r  <= hold_cnt_s;
        end
    end

    assign gnt      = gnt_r;
    assign busy     = busy_r;
    assign shift_en = shift_en_r;
    assign sdo      = sdo_r;
    assign done     = done_r;

endmodule

// File: tb/tb_siso_shift_sched.sv
// Scoreboard bench for siso_shift_sched: random requests, expected per-cycle
// output traces computed from the burst/hold rules and compared by a monitor.
module tb_siso_shift_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] data0, data1;
    logic [1:0] gnt;
    logic       busy, shift_en, sdo, done;

    logic [1:0] req5;
    logic [4:0] d5;
    logic [1:0] gnt_a, gnt_b;
    logic       busy_a, se_a, sdo_a, done_a;
    logic       busy_b, se_b, sdo_b, done_b;

    always #5 clk = ~clk;

    siso_shift_sched #(.WIDTH(8), .SHIFT_CYC(2), .HOLD_CYC(2)) dut (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt), .busy(busy), .shift_en(shift_en), .sdo(sdo), .done(done));

    siso_shift_sched #(.WIDTH(5), .SHIFT_CYC(2), .HOLD_CYC(3)) dut_h3 (
        .clk(clk), .rst(rst), .req(req5), .data0(d5), .data1(5'd0),
        .gnt(gnt_a), .busy(busy_a), .shift_en(se_a), .sdo(sdo_a), .done(done_a));

    siso_shift_sched #(.WIDTH(5), .SHIFT_CYC(2), .HOLD_CYC(0)) dut_h0 (
        .clk(clk), .rst(rst), .req(req5), .data0(d5), .data1(5'd0),
        .gnt(gnt_b), .busy(busy_b), .shift_en(se_b), .sdo(sdo_b), .done(done_b));

    // Trace element: {gnt[1:0], busy, shift_en, sdo, done}
    typedef logic [5:0] trace_t[$];
    typedef struct {
        logic [1:0]  g;
        logic [31:0] w;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    logic model_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected cycle-by-cycle outputs of one transfer, starting with the cycle after grant.
    function automatic trace_t model_trace(input logic [1:0] g, input logic [31:0] w,
                                           input int width, input int sc, input int hc);
        trace_t t;
        for (int i = 0; i < width; i++) begin
            t.push_back({g, 1'b1, 1'b1, w[i], 1'b0});
            if (((i + 1) % sc == 0) && (i + 1 < width))
                for (int h = 0; h < hc; h++) t.push_back({g, 1'b1, 1'b0, w[i+1], 1'b0});
        end
        t.push_back({g, 1'b1, 1'b0, 1'b0, 1'b1});
        return t;
    endfunction

    // Monitor: pops the expected transfer on each grant and compares every cycle.
    initial begin
        trace_t     t;
        exp_t       e;
        logic [5:0] m;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (gnt == 2'b00) begin
                    chk("idle_out", 32'({gnt, busy, shift_en, sdo, done}), 32'(0));
                end else if (sbq.size() == 0) begin
                    chk("unexpected_grant", 32'(gnt), 32'(0));
                end else begin
                    e = sbq.pop_front();
                    t = model_trace(e.g, e.w, 8, 2, 2);
                    for (int k = 0; k < t.size(); k++) begin
                        if (k > 0) @(negedge clk);
                        m = t[k][0] ? 6'b111101 : 6'b111111;
                        chk($sformatf("xfer_cycle%0d", k),
                            32'({gnt, busy, shift_en, sdo, done} & m), 32'(t[k] & m));
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0]  r;
        logic        win;
        logic [7:0]  w0, w1;
        int          len;
        trace_t      ta, tb, ra, rb;
        logic [10:0] sea;
        logic [4:0]  seb;

        rst = 1'b1; req = 2'b00; data0 = 8'h00; data1 = 8'h00; req5 = 2'b00; d5 = 5'd0;
        repeat (2) @(posedge clk);

        // Reset asserted between edges must clear outputs without a clock edge.
        @(negedge clk); rst = 1'b0; req = 2'b01; data0 = 8'hA5;
        @(posedge clk); #1;
        chk("grant_first", 32'({gnt, busy, shift_en, sdo}), 32'(5'b01111));
        req = 2'b00;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst", 32'({gnt, busy, shift_en, sdo, done}), 32'(0));
        @(negedge clk); rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_rst", 32'({gnt, busy, shift_en, sdo, done}), 32'(0));
        end

        // Reset during the second hold of a transfer: no done, outputs cleared.
        req = 2'b01; data0 = 8'hA5;
        @(posedge clk); #1 req = 2'b00;
        repeat (7) @(negedge clk);
        chk("second_hold", 32'({busy, shift_en, sdo, done}), 32'(4'b1000));
        #2 rst = 1'b1;
        #1 chk("rst_in_hold", 32'({gnt, busy, shift_en, sdo, done}), 32'(0));
        repeat (2) begin
            @(negedge clk);
            chk("no_done_in_rst", 32'({gnt, busy, shift_en, done}), 32'(0));
        end
        rst = 1'b0;
        model_ptr = 1'b0;
        @(posedge clk); #1 mon_en = 1'b1;

        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            w0 = 8'($urandom); w1 = 8'($urandom);
            if (n < 2)       begin r = 2'b11; w0 = 8'h0F; w1 = 8'hF0; end
            else if (n < 6)  r = 2'b11;
            else if (n == 6) begin r = 2'b01; w0 = 8'hA5; end
            else             r = 2'($urandom_range(0, 3));
            req = r; data0 = w0; data1 = w1;
            if (r != 2'b00) begin
                win = (r == 2'b11) ? model_ptr : r[1];
                model_ptr = ~win;
                sbq.push_back('{g: (win ? 2'b10 : 2'b01), w: 32'(win ? w1 : w0)});
                len = model_trace(2'b01, 32'(0), 8, 2, 2).size();
                @(posedge clk);
                repeat (len) begin
                    @(negedge clk);
                    req = 2'($urandom); data0 = 8'($urandom); data1 = 8'($urandom);
                end
            end else begin
                @(posedge clk);
            end
        end
        @(negedge clk); req = 2'b00;
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'(0));
        mon_en = 1'b0;

        // Short word with a truncated final burst, with and without holds.
        @(negedge clk); req5 = 2'b01; d5 = 5'b10110;
        @(posedge clk); #1 req5 = 2'b00;
        ta = model_trace(2'b01, 32'(5'b10110), 5, 2, 3);
        tb = model_trace(2'b01, 32'(5'b10110), 5, 2, 0);
        for (int k = 0; k < ta.size(); k++) begin
            @(negedge clk);
            ra.push_back({gnt_a, busy_a, se_a, sdo_a, done_a});
            if (k < tb.size()) rb.push_back({gnt_b, busy_b, se_b, sdo_b, done_b});
        end
        sea = '0;
        seb = '0;
        for (int k = 0; k < ta.size(); k++) begin
            chk($sformatf("w5h3_cycle%0d", k), 32'(ra[k] & (ta[k][0] ? 6'b111101 : 6'b111111)),
                32'(ta[k] & (ta[k][0] ? 6'b111101 : 6'b111111)));
            if (k < 11) sea = {sea[9:0], ra[k][2]};
        end
        for (int k = 0; k < tb.size(); k++) begin
            chk($sformatf("w5h0_cycle%0d", k), 32'(rb[k] & (tb[k][0] ? 6'b111101 : 6'b111111)),
                32'(tb[k] & (tb[k][0] ? 6'b111101 : 6'b111111)));
            if (k < 5) seb = {seb[3:0], rb[k][2]};
        end
        chk("w5h3_shift_en", 32'(sea), 32'(11'b11000110001));
        chk("w5h3_done", 32'(ra[11][0]), 32'(1));
        chk("w5h0_shift_en", 32'(seb), 32'(5'b11111));
        chk("w5h0_done", 32'(rb[5][0]), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
